// File: rtl/cordic_iter_ctrl.sv
// cordic_iter_ctrl
// Iteration sequencer for the hyperbolic CORDIC exponential core. Reads the
// per-iteration shift amount from LUT_SHIFT, holds it stable in shift_amt_o
// and strobes the X/Y/Z datapath: one load pulse, then N_ITER iterate pulses.
// After the last iteration, rdy_o is held until ack_fsm_i is seen.
//
// Optional build macro: CORDIC_ROM_OVERLAP_EN
//   When defined, the ROM read for iteration i+1 is issued during the UPDATE
//   cycle of iteration i. This gives 2-cycle iterations in place of 3-cycle
//   ones. Ports and reset behaviour are the same in both builds.
//
// Parameters
//   P       width of the shift amount (matches LUT_SHIFT data width)
//   N_ITER  iterations per operation, 1..32
//
// Ports
//   clk_i        system clock, rising edge
//   rst_i        synchronous active-high reset
//   beg_fsm_i    start request, sampled only in IDLE
//   ack_fsm_i    result acknowledge, sampled only in DONE
//   shift_in_i   LUT_SHIFT data, valid one cycle after en_rom1_o
//   en_rom1_o    LUT_SHIFT read enable
//   adrs_o       LUT_SHIFT address
//   shift_amt_o  registered shift amount for the datapath shifters
//   iter_idx_o   current iteration index
//   load_regs_o  one-cycle pulse: load initial X/Y/Z
//   en_iter_o    one-cycle pulse: perform one micro-rotation
//   rdy_o        result valid, held until acknowledged
//
// state     | meaning
// ----------+---------------------------------------------------------------
// S_IDLE    | waiting for beg_fsm_i
// S_LOAD    | load_regs_o high, counter cleared
// S_ROM_RD  | en_rom1_o high, adrs_o = counter
// S_CAPTURE | LUT data registered into shift_amt_o on the exit edge
// S_UPDATE  | en_iter_o high; either finish or advance the counter
// S_DONE    | rdy_o high until ack_fsm_i
module cordic_iter_ctrl #(
  parameter int P      = 5,
  parameter int N_ITER = 25
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         beg_fsm_i,
  input  logic         ack_fsm_i,
  input  logic [P-1:0] shift_in_i,
  output logic         en_rom1_o,
  output logic [4:0]   adrs_o,
  output logic [P-1:0] shift_amt_o,
  output logic [4:0]   iter_idx_o,
  output logic         load_regs_o,
  output logic         en_iter_o,
  output logic         rdy_o
);

  localparam logic [4:0] LAST_IDX = 5'(N_ITER - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ROM_RD,
    S_CAPTURE,
    S_UPDATE,
    S_DONE
  } state_e;

  state_e       state_q;
  logic [4:0]   cnt_q;
  logic [4:0]   adrs_q;
  logic [P-1:0] shift_amt_q;
  logic         en_rom1_q;
  logic         load_regs_q;
  logic         en_iter_q;
  logic         rdy_q;
  logic [4:0]   cnt_inc_d;

  assign cnt_inc_d = cnt_q + 5'd1;

  // Outputs are registered together with the state, so each pulse is set on
  // the edge that enters the state it belongs to.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      adrs_q      <= '0;
      shift_amt_q <= '0;
      en_rom1_q   <= 1'b0;
      load_regs_q <= 1'b0;
      en_iter_q   <= 1'b0;
      rdy_q       <= 1'b0;
    end else begin
      load_regs_q <= 1'b0;
      en_rom1_q   <= 1'b0;
      en_iter_q   <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (beg_fsm_i) begin
            state_q     <= S_LOAD;
            load_regs_q <= 1'b1;
            cnt_q       <= '0;
            adrs_q      <= '0;
          end
        end
        S_LOAD: begin
          state_q   <= S_ROM_RD;
          en_rom1_q <= 1'b1;
        end
        S_ROM_RD: begin
          state_q <= S_CAPTURE;
        end
        S_CAPTURE: begin
          shift_amt_q <= shift_in_i;
          en_iter_q   <= 1'b1;
          state_q     <= S_UPDATE;
`ifdef CORDIC_ROM_OVERLAP_EN
          // Prefetch the next shift amount during UPDATE; the last
          // iteration has nothing left to fetch.
          if (cnt_q != LAST_IDX) begin
            en_rom1_q <= 1'b1;
            adrs_q    <= cnt_inc_d;
          end
`endif
        end
        S_UPDATE: begin
          if (cnt_q == LAST_IDX) begin
            state_q <= S_DONE;
            rdy_q   <= 1'b1;
          end else begin
            cnt_q  <= cnt_inc_d;
            adrs_q <= cnt_inc_d;
`ifdef CORDIC_ROM_OVERLAP_EN
            state_q <= S_CAPTURE;
`else
            state_q   <= S_ROM_RD;
            en_rom1_q <= 1'b1;
`endif
          end
        end
        S_DONE: begin
          if (ack_fsm_i) begin
            state_q <= S_IDLE;
            rdy_q   <= 1'b0;
          end
        end
        default: begin
          state_q <= S_IDLE;
          rdy_q   <= 1'b0;
        end
      endcase
    end
  end

  assign en_rom1_o   = en_rom1_q;
  assign adrs_o      = adrs_q;
  assign shift_amt_o = shift_amt_q;
  assign iter_idx_o  = cnt_q;
  assign load_regs_o = load_regs_q;
  assign en_iter_o   = en_iter_q;
  assign rdy_o       = rdy_q;

endmodule

// File: tb/tb_cordic_iter_ctrl.sv
// Testbench for cordic_iter_ctrl. Three instances (N_ITER = 25, 1, 32) are
// each paired with a registered LUT_SHIFT model. Expected EN_ITER and RDY
// events are queued when an operation starts. They are popped and compared
// as the DUT produces them.
module tb_cordic_iter_ctrl;

`ifdef CORDIC_ROM_OVERLAP_EN
  localparam bit OVL = 1'b1;
`else
  localparam bit OVL = 1'b0;
`endif
  localparam int NS [3] = '{25, 1, 32};

  typedef struct {
    int k;
    int kind;  // 0 = EN_ITER, 1 = RDY rise
    int idx;
    int sh;
    int cy;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       beg      [3];
  logic       ack      [3];
  logic [4:0] lut_q    [3];
  logic       en_rom   [3];
  logic [4:0] adrs     [3];
  logic [4:0] shamt    [3];
  logic [4:0] iter     [3];
  logic       load     [3];
  logic       eni      [3];
  logic       rdy      [3];

  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  int   t0       [3];
  int   rom_exp  [3];
  int   rom_cnt  [3];
  logic exp_load [3];
  logic rdy_prev [3];
  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [4:0] lut_f(input int a);
    if (a == 0)       return 5'd0;
    else if (a <= 5)  return 5'(a - 1);
    else if (a <= 15) return 5'(a - 2);
    else              return 5'(a - 3);
  endfunction

  // LUT_SHIFT models: registered read, data valid the cycle after enable
  always @(posedge clk) begin
    for (int k = 0; k < 3; k++)
      if (en_rom[k]) lut_q[k] <= lut_f(int'(adrs[k]));
  end

  cordic_iter_ctrl #(.P(5), .N_ITER(25)) u_n25 (
    .clk_i(clk), .rst_i(rst), .beg_fsm_i(beg[0]), .ack_fsm_i(ack[0]),
    .shift_in_i(lut_q[0]), .en_rom1_o(en_rom[0]), .adrs_o(adrs[0]),
    .shift_amt_o(shamt[0]), .iter_idx_o(iter[0]), .load_regs_o(load[0]),
    .en_iter_o(eni[0]), .rdy_o(rdy[0]));

  cordic_iter_ctrl #(.P(5), .N_ITER(1)) u_n1 (
    .clk_i(clk), .rst_i(rst), .beg_fsm_i(beg[1]), .ack_fsm_i(ack[1]),
    .shift_in_i(lut_q[1]), .en_rom1_o(en_rom[1]), .adrs_o(adrs[1]),
    .shift_amt_o(shamt[1]), .iter_idx_o(iter[1]), .load_regs_o(load[1]),
    .en_iter_o(eni[1]), .rdy_o(rdy[1]));

  cordic_iter_ctrl #(.P(5), .N_ITER(32)) u_n32 (
    .clk_i(clk), .rst_i(rst), .beg_fsm_i(beg[2]), .ack_fsm_i(ack[2]),
    .shift_in_i(lut_q[2]), .en_rom1_o(en_rom[2]), .adrs_o(adrs[2]),
    .shift_amt_o(shamt[2]), .iter_idx_o(iter[2]), .load_regs_o(load[2]),
    .en_iter_o(eni[2]), .rdy_o(rdy[2]));

  task automatic chk(input string tag, input int obs, input int exp_v);
    n_chk++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, exp_v, cyc);
    end
  endtask

  // Advance to the next falling edge and check every DUT event seen there.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      if (load[k]) begin
        chk("load_expected", int'(exp_load[k]), 1);
        if (exp_load[k]) chk("load_cycle", cyc - t0[k], 1);
        exp_load[k] = 1'b0;
      end
      if (en_rom[k]) begin
        chk("rom_adrs", int'(adrs[k]), rom_exp[k]);
        rom_exp[k]++;
        rom_cnt[k]++;
      end
      if (eni[k]) begin
        if (sb.size() == 0) chk("iter_unexpected", int'(eni[k]), 0);
        else begin
          e = sb.pop_front();
          chk("iter_inst", e.k, k);
          chk("iter_kind", e.kind, 0);
          chk("iter_idx", int'(iter[k]), e.idx);
          chk("iter_shamt", int'(shamt[k]), e.sh);
          chk("iter_cycle", cyc - t0[k], e.cy);
        end
      end
      if (rdy[k] && !rdy_prev[k]) begin
        if (sb.size() == 0) chk("rdy_unexpected", int'(rdy[k]), 0);
        else begin
          e = sb.pop_front();
          chk("rdy_inst", e.k, k);
          chk("rdy_kind", e.kind, 1);
          chk("rdy_cycle", cyc - t0[k], e.cy);
        end
      end
      rdy_prev[k] = rdy[k];
    end
  endtask

  // Called at a falling edge: raise BEG_FSM and queue the expected events.
  task automatic start_op(input int k);
    exp_t e;
    beg[k]      = 1'b1;
    t0[k]       = cyc;
    exp_load[k] = 1'b1;
    rom_exp[k]  = 0;
    rom_cnt[k]  = 0;
    for (int i = 0; i < NS[k]; i++) begin
      e.k = k; e.kind = 0; e.idx = i; e.sh = int'(lut_f(i));
      e.cy = OVL ? 4 + 2 * i : 4 + 3 * i;
      sb.push_back(e);
    end
    e.k = k; e.kind = 1; e.idx = 0; e.sh = 0;
    e.cy = OVL ? 3 + 2 * NS[k] : 2 + 3 * NS[k];
    sb.push_back(e);
    tick();
    beg[k] = 1'b0;
  endtask

  task automatic wait_rdy(input int k, input int budget);
    int n = 0;
    while (!rdy[k] && n < budget) begin
      tick();
      n++;
    end
    chk("rdy_seen", int'(rdy[k]), 1);
    chk("rom_count", rom_cnt[k], NS[k]);
    chk("sb_drained", sb.size(), 0);
  endtask

  task automatic do_ack(input int k);
    ack[k] = 1'b1;
    tick();
    ack[k] = 1'b0;
    chk("ack_rdy_low", int'(rdy[k]), 0);
    chk("ack_no_iter", int'(eni[k]), 0);
  endtask

  task automatic check_zero(input int k);
    chk("outputs_zero", int'({en_rom[k], adrs[k], shamt[k], iter[k],
                              load[k], eni[k], rdy[k]}), 0);
  endtask

  task automatic wait_iter(input int k, input int idx);
    int n = 0;
    while (int'(iter[k]) != idx && n < 200) begin
      tick();
      n++;
    end
    chk("iter_reached", int'(iter[k]), idx);
  endtask

  initial begin
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      beg[k] = 1'b0; ack[k] = 1'b0; t0[k] = 0; rom_exp[k] = 0;
      rom_cnt[k] = 0; exp_load[k] = 1'b0; rdy_prev[k] = 1'b0;
    end
    tick();
    tick();
    for (int k = 0; k < 3; k++) check_zero(k);
    rst = 1'b0;
    tick();

    // basic run, then hold RDY without acknowledge
    start_op(0);
    wait_rdy(0, 200);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("rdy_hold", int'(rdy[0]), 1);
    end
    do_ack(0);
    for (int i = 0; i < 5; i++) tick();

    // starts outside IDLE are ignored
    start_op(0);
    wait_iter(0, 3);
    beg[0] = 1'b1; tick(); beg[0] = 1'b0;
    wait_iter(0, 10);
    beg[0] = 1'b1; tick(); beg[0] = 1'b0;
    wait_rdy(0, 200);
    beg[0] = 1'b1; tick(); beg[0] = 1'b0;
    tick();
    chk("done_beg_ignored", int'(rdy[0]), 1);
    do_ack(0);
    for (int i = 0; i < 20; i++) tick();

    // reset in the CAPTURE cycle of iteration 12
    start_op(0);
    begin
      int n = 0;
      int cap = OVL ? 3 + 2 * 12 : 3 + 3 * 12;
      while (cyc - t0[0] != cap && n < 200) begin
        tick();
        n++;
      end
      chk("capture12_reached", cyc - t0[0], cap);
    end
    rst = 1'b1;
    tick();
    check_zero(0);
    rst = 1'b0;
    sb.delete();
    exp_load[0] = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    start_op(0);
    wait_rdy(0, 200);
    do_ack(0);

    // BEG_FSM and ACK_FSM together in DONE, then start straight away
    start_op(0);
    wait_rdy(0, 200);
    beg[0] = 1'b1;
    ack[0] = 1'b1;
    tick();
    ack[0] = 1'b0;
    chk("sim_rdy_low", int'(rdy[0]), 0);
    chk("sim_no_load", int'(load[0]), 0);
    start_op(0);
    wait_rdy(0, 200);
    do_ack(0);

    // N_ITER = 1 and N_ITER = 32
    start_op(1);
    wait_rdy(1, 50);
    do_ack(1);
    start_op(2);
    wait_rdy(2, 250);
    chk("n32_last_idx", int'(iter[2]), 31);
    do_ack(2);
    for (int i = 0; i < 5; i++) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
